// File: rtl/out_sample_fifo.sv
// out_sample_fifo: first-word-fall-through sample buffer with a ready/valid output and sticky overflow.
// Define OSF_DROP_CNT_EN to add the saturating drop counter and its drop_cnt port.
module out_sample_fifo #(
  parameter int WIDTH  = 14,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic              in_stb,
  input  logic              in_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr
`ifdef OSF_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr, rd_ptr;
  logic             full, push, pop, wr_en, drop;
  assign push      = in_stb & in_valid;
  assign out_valid = wr_ptr != rd_ptr;
  assign pop       = out_valid & out_ready;
  assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_W{1'b0}}};
  // a full fifo still accepts a push when the head leaves on the same edge
  assign wr_en     = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign level     = wr_ptr - rd_ptr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[ADDR_W-1:0]] <= in;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      overflow <= ovf_clr ? 1'b0 : (overflow | drop);
    end
  end
`ifdef OSF_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else drop_cnt <= ovf_clr ? '0 : (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
  end
`endif
endmodule

// File: tb/tb_out_sample_fifo.sv
// tb_out_sample_fifo: directed self-checking bench for out_sample_fifo.
module tb_out_sample_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] din;
  logic        in_stb, in_valid, out_ready, ovf_clr;
  logic [13:0] out_data;
  logic        out_valid, overflow;
  logic [4:0]  level;
`ifdef OSF_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif
  int cmps = 0;
  int errs = 0;
  logic [13:0] q[$];

  out_sample_fifo dut (
    .clk(clk), .rst(rst), .in(din), .in_stb(in_stb), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef OSF_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmps++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] v);
    din = v;
    in_stb = 1'b1;
    in_valid = 1'b1;
    step();
    in_stb = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; in_stb = 0; in_valid = 0; out_ready = 0; ovf_clr = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
`ifdef OSF_DROP_CNT_EN
    chk("rst_cnt", drop_cnt, 0);
`endif
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);

    // single push, then hold with no consumer
    push(14'h1234);
    chk("p1_valid", out_valid, 1);
    chk("p1_data", out_data, 14'h1234);
    chk("p1_level", level, 1);
    repeat (20) step();
    chk("hold_valid", out_valid, 1);
    chk("hold_data", out_data, 14'h1234);
    out_ready = 1; step(); out_ready = 0;
    chk("p1_empty", out_valid, 0);
    chk("p1_level0", level, 0);

    // fill then one dropped sample
    for (int i = 0; i < 16; i++) push(14'(i));
    chk("full_level", level, 16);
    chk("full_ovf0", overflow, 0);
    push(14'h3FFF);
    chk("drop_level", level, 16);
    chk("drop_ovf", overflow, 1);
`ifdef OSF_DROP_CNT_EN
    chk("drop_cnt1", drop_cnt, 1);
`endif
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", out_data, 14'(i));
      step();
    end
    out_ready = 0;
    chk("drain_empty", out_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);
    ovf_clr = 1; step(); ovf_clr = 0;
    chk("clr_ovf", overflow, 0);
`ifdef OSF_DROP_CNT_EN
    chk("clr_cnt", drop_cnt, 0);
`endif

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(14'h100 + 14'(i));
    din = 14'h0AAA; in_stb = 1; in_valid = 1; out_ready = 1;
    step();
    in_stb = 0; out_ready = 0;
    chk("pp_level", level, 16);
    chk("pp_ovf", overflow, 0);
    out_ready = 1;
    for (int i = 1; i < 16; i++) begin
      chk("pp_data", out_data, 14'h100 + 14'(i));
      step();
    end
    chk("pp_last", out_data, 14'h0AAA);
    step();
    out_ready = 0;
    chk("pp_empty", out_valid, 0);

    // saturating drops, then clear racing a drop
    for (int i = 0; i < 16; i++) push(14'h200 + 14'(i));
    din = 14'h3333; in_stb = 1; in_valid = 1;
    repeat (300) step();
    chk("sat_level", level, 16);
    chk("sat_ovf", overflow, 1);
`ifdef OSF_DROP_CNT_EN
    chk("sat_cnt", drop_cnt, 255);
`endif
    ovf_clr = 1; step(); ovf_clr = 0; in_stb = 0;
    chk("clrprio_ovf", overflow, 0);
`ifdef OSF_DROP_CNT_EN
    chk("clrprio_cnt", drop_cnt, 0);
`endif
    chk("sat_head", out_data, 14'h200);
    out_ready = 1; repeat (16) step(); out_ready = 0;
    chk("sat_drained", level, 0);

    // streaming with a bursty consumer across many pointer wraps
    for (int c = 0; c < 7680; c++) begin
      in_valid = 1;
      in_stb = (c % 12 == 0);
      din = 14'((c * 37 + 5) & 14'h3FFF);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stream_extra", out_valid, 0);
        else chk("stream_data", out_data, q.pop_front());
      end
      if (in_stb) q.push_back(din);
      chk("stream_lvl_max", level > 16, 0);
      step();
    end
    in_stb = 0; out_ready = 1;
    for (int c = 0; c < 20 && out_valid; c++) begin
      if (q.size() == 0) chk("tail_extra", out_valid, 0);
      else chk("tail_data", out_data, q.pop_front());
      step();
    end
    out_ready = 0;
    chk("stream_left", q.size(), 0);
    chk("stream_empty", out_valid, 0);
    chk("stream_ovf", overflow, 0);

    // strobes without in_valid are ignored
    in_valid = 0; in_stb = 1; din = 14'h0777;
    repeat (5) step();
    in_stb = 0;
    chk("inv_level", level, 0);
    chk("inv_valid", out_valid, 0);

    // asynchronous reset with data buffered
    for (int i = 0; i < 5; i++) push(14'h0040 + 14'(i));
    chk("pre_rst_level", level, 5);
    #2 rst = 1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_level", level, 0);
    @(posedge clk); #1 rst = 0;
    push(14'h0055);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 14'h0055);
    chk("post_rst_level", level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/out_sample_fifo.md
# out_sample_fifo

Output buffer placed directly downstream of the hybrid fixed-point filter. Captures each decimated 14-bit filter sample on a one-cycle strobe in the fast modulator clock domain and holds it in a small FIFO. Presents samples on a ready/valid stream so a slower or bursty consumer (serializer, bus bridge) can drain them. Detects overflow and optionally counts dropped samples.

## Interface
- `WIDTH`, 14: sample width; equals the filter output width (offset binary).
- `ADDR_W`, 4: log2 of capacity; the block holds 2^ADDR_W samples in total.
- `CNT_W`, 8: drop counter width.

- `clk`  in  1  fast modulator clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  WIDTH  filter output sample.
- `in_stb`  in  1  one-cycle pulse per decimated sample, aligned so that `in` is stable.
- `in_valid`  in  1  filter `valid` level; samples are ignored while low.
- `out_data`  out  WIDTH  head sample.
- `out_valid`  out  1  `out_data` holds a sample.
- `out_ready`  in  1  consumer accepts the head sample.
- `level`  out  ADDR_W+1  number of samples held, 0..2^ADDR_W.
- `overflow`  out  1  sticky flag; at least one sample was dropped.
- `ovf_clr`  in  1  synchronous clear of `overflow` and of the drop counter.
- `drop_cnt`  out  CNT_W  saturating count of dropped samples; present only with `OSF_DROP_CNT_EN`.

## Operation
- push = `in_stb & in_valid`. pop = `out_valid & out_ready`.
- Storage is a circular RAM of 2^ADDR_W words with read/write pointers of ADDR_W+1 bits. The extra MSB distinguishes full from empty.
  - empty: pointers are equal.
  - full: pointers differ only in the MSB.
- The head register is first-word-fall-through. `out_data` always equals the oldest stored sample whenever `out_valid`=1.
- Push is accepted if the FIFO is not full, or if the FIFO is full and pop occurs in the same cycle.
- Push while full without pop drops the incoming sample:
  - FIFO contents are unchanged.
  - `overflow` is set.
  - The drop counter increments.
- Pop while empty cannot occur, because `out_valid`=0.
- A simultaneous push and pop leaves `level` unchanged and advances both pointers.
- Pointers wrap modulo 2^(ADDR_W+1). The RAM index is the ADDR_W LSBs.
- `in` is stored unmodified; there is no format conversion.
- `ovf_clr` takes priority over a drop in the same cycle. The result is `overflow`=0 and the counter at 0.
- `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- `in_valid` low does not flush the FIFO. Samples already stored remain drainable.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `level`=0, `overflow`=0, `drop_cnt`=0, both pointers 0.
- Latency from push to output: a push accepted at clock edge k, into an empty FIFO, gives `out_valid`=1 with that sample after edge k (visible in cycle k+1).
- After pop at edge k, the next sample (if any) is on `out_data` after edge k. This allows back-to-back pops at one per clock.
- `level` is registered. It reflects all pushes and pops up to and including the last edge.
- `overflow` and `drop_cnt` update at the edge of the dropped push.
- Asserting `rst` mid-operation immediately clears all state asynchronously. Buffered samples are discarded. The first edge after `rst` deasserts may accept a push.
- Throughput: one push and one pop per clock. In normal use pushes arrive every DSR clocks.

## Configuration
- `OSF_DROP_CNT_EN` defined:
  - `drop_cnt` port and counter exist.
  - The counter saturates at 2^CNT_W−1.
  - `ovf_clr` clears it.
- Not defined:
  - No counter and no `drop_cnt` port.
  - `overflow` and all other behaviour are unchanged.

## Test plan
- Reset, then push 0x1234 with `out_ready`=0 → `out_valid`=1 and `out_data`=0x1234 one cycle later; `level`=1; data is held for 20 idle cycles.
- Push 16 samples 0x0000..0x000F, then a 17th sample 0x3FFF, with `out_ready`=0 → `level`=16; `overflow`=1; `drop_cnt`=1; draining yields 0x0000..0x000F in order and never 0x3FFF.
- Full FIFO with simultaneous push of 0x0AAA and `out_ready`=1 → no drop; `level` stays 16; 0x0AAA is the last sample drained.
- Push 300 samples while full with `OSF_DROP_CNT_EN` → `drop_cnt`=255; then `ovf_clr` for one cycle → `overflow`=0 and `drop_cnt`=0.
- Pushes every 12 cycles with `out_ready` toggling pseudo-randomly, over 40 pointer wraps → output sequence equals input sequence; `level` never exceeds 16; no drops.
- `in_valid`=0 with strobes present → nothing stored. `rst` pulsed with 5 samples stored → `out_valid`=0 and `level`=0 immediately, before the next clock edge.
